// File: rtl/int_issue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : int_issue_scheduler                                             |
// | Purpose  : Collapsing issue queue with oldest-first select and CDB wakeup. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module int_issue_scheduler #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dispatch_en_integer,
   input  logic [3:0]        dispatch_opcode,
   input  logic [TAG_W-1:0]  dispatch_rd_tag,
   input  logic [TAG_W-1:0]  dispatch_rs1_tag,
   input  logic [TAG_W-1:0]  dispatch_rs2_tag,
   input  logic              dispatch_rs1_rdy,
   input  logic              dispatch_rs2_rdy,
   input  logic [DATA_W-1:0] dispatch_rs1_data,
   input  logic [DATA_W-1:0] dispatch_rs2_data,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              flush,
   output logic              issueque_full_integer,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [3:0]        issue_opcode,
   output logic [DATA_W-1:0] issue_rs1_data,
   output logic [DATA_W-1:0] issue_rs2_data,
   output logic [TAG_W-1:0]  issue_rd_tag
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [3:0]        r_op   [DEPTH];
   logic [TAG_W-1:0]  r_rd   [DEPTH];
   logic [TAG_W-1:0]  r_tag1 [DEPTH];
   logic [TAG_W-1:0]  r_tag2 [DEPTH];
   logic              r_rdy1 [DEPTH];
   logic              r_rdy2 [DEPTH];
   logic [DATA_W-1:0] r_dat1 [DEPTH];
   logic [DATA_W-1:0] r_dat2 [DEPTH];
   logic [CNT_W-1:0]  r_count;
   logic              r_full;

   logic [3:0]        n_op   [DEPTH];
   logic [TAG_W-1:0]  n_rd   [DEPTH];
   logic [TAG_W-1:0]  n_tag1 [DEPTH];
   logic [TAG_W-1:0]  n_tag2 [DEPTH];
   logic              n_rdy1 [DEPTH];
   logic              n_rdy2 [DEPTH];
   logic [DATA_W-1:0] n_dat1 [DEPTH];
   logic [DATA_W-1:0] n_dat2 [DEPTH];

   logic              w_found;
   logic [IDX_W-1:0]  w_sel;
   logic              w_fire;
   logic              w_accept;
   logic [CNT_W-1:0]  w_wr_idx;
   logic [CNT_W-1:0]  w_count_next;

   // Descending scan so the lowest ready slot (oldest) wins.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (CNT_W'(i) < r_count && r_rdy1[i] && r_rdy2[i]) begin
            w_found = 1'b1;
            w_sel   = IDX_W'(i);
         end
      end
   end

   assign w_fire       = w_found && issue_ready;
   assign w_accept     = dispatch_en_integer && !r_full;
   assign w_wr_idx     = r_count - CNT_W'(w_fire);
   assign w_count_next = r_count + CNT_W'(w_accept) - CNT_W'(w_fire);

   assign issueque_full_integer = r_full;
   assign issue_valid           = w_found;
   assign issue_opcode          = w_found ? r_op[w_sel]   : '0;
   assign issue_rs1_data        = w_found ? r_dat1[w_sel] : '0;
   assign issue_rs2_data        = w_found ? r_dat2[w_sel] : '0;
   assign issue_rd_tag          = w_found ? r_rd[w_sel]   : '0;

   // Order matters: collapse, then write the new entry, then wake up, so the
   // new entry also picks up a same-cycle broadcast.
   always_comb begin
      n_op   = r_op;
      n_rd   = r_rd;
      n_tag1 = r_tag1;
      n_tag2 = r_tag2;
      n_rdy1 = r_rdy1;
      n_rdy2 = r_rdy2;
      n_dat1 = r_dat1;
      n_dat2 = r_dat2;
      if (w_fire) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (IDX_W'(i) >= w_sel) begin
               n_op[i]   = r_op[i+1];
               n_rd[i]   = r_rd[i+1];
               n_tag1[i] = r_tag1[i+1];
               n_tag2[i] = r_tag2[i+1];
               n_rdy1[i] = r_rdy1[i+1];
               n_rdy2[i] = r_rdy2[i+1];
               n_dat1[i] = r_dat1[i+1];
               n_dat2[i] = r_dat2[i+1];
            end
         end
         n_op[DEPTH-1]   = '0;
         n_rd[DEPTH-1]   = '0;
         n_tag1[DEPTH-1] = '0;
         n_tag2[DEPTH-1] = '0;
         n_rdy1[DEPTH-1] = 1'b0;
         n_rdy2[DEPTH-1] = 1'b0;
         n_dat1[DEPTH-1] = '0;
         n_dat2[DEPTH-1] = '0;
      end
      if (w_accept) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == w_wr_idx) begin
               n_op[i]   = dispatch_opcode;
               n_rd[i]   = dispatch_rd_tag;
               n_tag1[i] = dispatch_rs1_tag;
               n_tag2[i] = dispatch_rs2_tag;
               n_rdy1[i] = dispatch_rs1_rdy;
               n_rdy2[i] = dispatch_rs2_rdy;
               n_dat1[i] = dispatch_rs1_data;
               n_dat2[i] = dispatch_rs2_data;
            end
         end
      end
      if (cdb_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < w_count_next) begin
               if (!n_rdy1[i] && n_tag1[i] == cdb_tag) begin
                  n_rdy1[i] = 1'b1;
                  n_dat1[i] = cdb_data;
               end
               if (!n_rdy2[i] && n_tag2[i] == cdb_tag) begin
                  n_rdy2[i] = 1'b1;
                  n_dat2[i] = cdb_data;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_op    <= '{default: '0};
         r_rd    <= '{default: '0};
         r_tag1  <= '{default: '0};
         r_tag2  <= '{default: '0};
         r_rdy1  <= '{default: 1'b0};
         r_rdy2  <= '{default: 1'b0};
         r_dat1  <= '{default: '0};
         r_dat2  <= '{default: '0};
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         r_op    <= n_op;
         r_rd    <= n_rd;
         r_tag1  <= n_tag1;
         r_tag2  <= n_tag2;
         r_rdy1  <= n_rdy1;
         r_rdy2  <= n_rdy2;
         r_dat1  <= n_dat1;
         r_dat2  <= n_dat2;
         r_count <= w_count_next;
         r_full  <= (w_count_next == CNT_W'(DEPTH));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_int_issue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_int_issue_scheduler                                          |
// | Purpose  : Directed self-checking bench for int_issue_scheduler.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_int_issue_scheduler;

   localparam int DEPTH  = 4;
   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              dispatch_en_integer;
   logic [3:0]        dispatch_opcode;
   logic [TAG_W-1:0]  dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag;
   logic              dispatch_rs1_rdy, dispatch_rs2_rdy;
   logic [DATA_W-1:0] dispatch_rs1_data, dispatch_rs2_data;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              flush;
   logic              issueque_full_integer;
   logic              issue_valid;
   logic              issue_ready;
   logic [3:0]        issue_opcode;
   logic [DATA_W-1:0] issue_rs1_data, issue_rs2_data;
   logic [TAG_W-1:0]  issue_rd_tag;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   int_issue_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .dispatch_en_integer  (dispatch_en_integer),
      .dispatch_opcode      (dispatch_opcode),
      .dispatch_rd_tag      (dispatch_rd_tag),
      .dispatch_rs1_tag     (dispatch_rs1_tag),
      .dispatch_rs2_tag     (dispatch_rs2_tag),
      .dispatch_rs1_rdy     (dispatch_rs1_rdy),
      .dispatch_rs2_rdy     (dispatch_rs2_rdy),
      .dispatch_rs1_data    (dispatch_rs1_data),
      .dispatch_rs2_data    (dispatch_rs2_data),
      .cdb_valid            (cdb_valid),
      .cdb_tag              (cdb_tag),
      .cdb_data             (cdb_data),
      .flush                (flush),
      .issueque_full_integer(issueque_full_integer),
      .issue_valid          (issue_valid),
      .issue_ready          (issue_ready),
      .issue_opcode         (issue_opcode),
      .issue_rs1_data       (issue_rs1_data),
      .issue_rs2_data       (issue_rs2_data),
      .issue_rd_tag         (issue_rd_tag)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are then stable for checking.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [3:0] op, input logic [TAG_W-1:0] rd,
                       input logic [TAG_W-1:0] t1, input logic r1, input logic [DATA_W-1:0] d1,
                       input logic [TAG_W-1:0] t2, input logic r2, input logic [DATA_W-1:0] d2);
      dispatch_en_integer = 1'b1;
      dispatch_opcode     = op;
      dispatch_rd_tag     = rd;
      dispatch_rs1_tag    = t1;
      dispatch_rs1_rdy    = r1;
      dispatch_rs1_data   = d1;
      dispatch_rs2_tag    = t2;
      dispatch_rs2_rdy    = r2;
      dispatch_rs2_data   = d2;
   endtask

   task automatic bcast(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
      cdb_valid = v;
      cdb_tag   = t;
      cdb_data  = d;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_count"}, 64'(dut.r_count), 64'd0);
      chk({tag, "_valid"}, 64'(issue_valid), 64'd0);
      chk({tag, "_full"},  64'(issueque_full_integer), 64'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; issue_ready = 1'b0;
      dispatch_en_integer = 1'b0;
      disp(4'h0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      dispatch_en_integer = 1'b0;
      bcast(1'b0, '0, '0);
      step(); step();
      rst = 1'b0;
      chk_empty("reset");
      chk("reset_op",  64'(issue_opcode), 64'd0);
      chk("reset_rs1", 64'(issue_rs1_data), 64'd0);
      chk("reset_rs2", 64'(issue_rs2_data), 64'd0);
      chk("reset_rd",  64'(issue_rd_tag), 64'd0);

      // Basic issue
      issue_ready = 1'b1;
      disp(4'h0, 6'd5, 6'd1, 1'b1, 32'd10, 6'd2, 1'b1, 32'd20);
      step();
      dispatch_en_integer = 1'b0;
      chk("basic_valid", 64'(issue_valid), 64'd1);
      chk("basic_op",    64'(issue_opcode), 64'd0);
      chk("basic_rs1",   64'(issue_rs1_data), 64'd10);
      chk("basic_rs2",   64'(issue_rs2_data), 64'd20);
      chk("basic_rd",    64'(issue_rd_tag), 64'd5);
      step();
      chk_empty("basic_after");

      // Oldest-first with wakeup: A waits on tag 7, B is ready
      issue_ready = 1'b0;
      disp(4'h1, 6'd1, 6'd7, 1'b0, 32'd0, 6'd3, 1'b1, 32'd3);
      step();
      disp(4'h2, 6'd2, 6'd4, 1'b1, 32'd4, 6'd5, 1'b1, 32'd5);
      step();
      dispatch_en_integer = 1'b0;
      chk("oldest_b_valid", 64'(issue_valid), 64'd1);
      chk("oldest_b_rd",    64'(issue_rd_tag), 64'd2);
      chk("oldest_b_op",    64'(issue_opcode), 64'd2);
      issue_ready = 1'b1;
      step();
      chk("oldest_a_wait", 64'(issue_valid), 64'd0);
      bcast(1'b1, 6'd7, 32'h55);
      step();
      bcast(1'b0, '0, '0);
      chk("wake_a_valid", 64'(issue_valid), 64'd1);
      chk("wake_a_rd",    64'(issue_rd_tag), 64'd1);
      chk("wake_a_rs1",   64'(issue_rs1_data), 64'h55);
      chk("wake_a_rs2",   64'(issue_rs2_data), 64'd3);
      step();
      chk_empty("wake_after");

      // Full boundary: four entries each waiting on tag 20+k
      issue_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         disp(4'(k), 6'(10 + k), 6'(20 + k), 1'b0, 32'd0, 6'd0, 1'b1, 32'(k));
         step();
      end
      chk("full_set",   64'(issueque_full_integer), 64'd1);
      chk("full_count", 64'(dut.r_count), 64'd4);
      disp(4'hF, 6'd15, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2);
      step();
      dispatch_en_integer = 1'b0;
      chk("full_ignore_count", 64'(dut.r_count), 64'd4);
      chk("full_ignore_valid", 64'(issue_valid), 64'd0);
      chk("full_ignore_full",  64'(issueque_full_integer), 64'd1);
      issue_ready = 1'b1;
      bcast(1'b1, 6'd22, 32'h99);
      step();
      bcast(1'b0, '0, '0);
      chk("slot2_valid", 64'(issue_valid), 64'd1);
      chk("slot2_rd",    64'(issue_rd_tag), 64'd12);
      chk("slot2_rs1",   64'(issue_rs1_data), 64'h99);
      chk("slot2_rs2",   64'(issue_rs2_data), 64'd2);
      step();
      chk("slot2_gone_count", 64'(dut.r_count), 64'd3);
      chk("slot2_gone_full",  64'(issueque_full_integer), 64'd0);
      chk("slot2_gone_valid", 64'(issue_valid), 64'd0);
      issue_ready = 1'b0;
      bcast(1'b1, 6'd23, 32'h33);
      step();
      chk("order_rd13", 64'(issue_rd_tag), 64'd13);
      bcast(1'b1, 6'd20, 32'h20);
      step();
      bcast(1'b0, '0, '0);
      chk("order_rd10", 64'(issue_rd_tag), 64'd10);
      chk("order_rs1",  64'(issue_rs1_data), 64'h20);

      // Flush with 3 entries, a dispatch pending and an issue offered
      issue_ready = 1'b1;
      flush = 1'b1;
      disp(4'h7, 6'd44, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 32'd8);
      step();
      flush = 1'b0;
      dispatch_en_integer = 1'b0;
      chk_empty("flush");

      // Dispatch/CDB bypass on rs2
      disp(4'h3, 6'd6, 6'd1, 1'b1, 32'd1, 6'd9, 1'b0, 32'd0);
      bcast(1'b1, 6'd9, 32'hAB);
      step();
      dispatch_en_integer = 1'b0;
      bcast(1'b0, '0, '0);
      chk("bypass_valid", 64'(issue_valid), 64'd1);
      chk("bypass_op",    64'(issue_opcode), 64'd3);
      chk("bypass_rs2",   64'(issue_rs2_data), 64'hAB);
      step();
      chk_empty("bypass_after");

      // Simultaneous issue and dispatch at count=2
      issue_ready = 1'b0;
      disp(4'h4, 6'd30, 6'd0, 1'b1, 32'd30, 6'd0, 1'b1, 32'd1);
      step();
      disp(4'h5, 6'd31, 6'd40, 1'b0, 32'd0, 6'd0, 1'b1, 32'd2);
      step();
      chk("simul_pre_rd", 64'(issue_rd_tag), 64'd30);
      issue_ready = 1'b1;
      disp(4'h6, 6'd32, 6'd0, 1'b1, 32'd32, 6'd0, 1'b1, 32'd3);
      step();
      dispatch_en_integer = 1'b0;
      chk("simul_count", 64'(dut.r_count), 64'd2);
      chk("simul_rd",    64'(issue_rd_tag), 64'd32);
      chk("simul_rs1",   64'(issue_rs1_data), 64'd32);
      step();
      chk("simul_g_gone", 64'(dut.r_count), 64'd1);
      chk("simul_f_wait", 64'(issue_valid), 64'd0);
      bcast(1'b1, 6'd40, 32'h40);
      step();
      bcast(1'b0, '0, '0);
      chk("simul_f_rd",  64'(issue_rd_tag), 64'd31);
      chk("simul_f_rs1", 64'(issue_rs1_data), 64'h40);
      step();
      chk_empty("simul_after");

      // Reset mid-operation
      issue_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         disp(4'(8 + k), 6'(50 + k), 6'd0, 1'b1, 32'(100 + k), 6'd0, 1'b1, 32'(200 + k));
         step();
      end
      chk("rst_pre_rd", 64'(issue_rd_tag), 64'd50);
      issue_ready = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      dispatch_en_integer = 1'b0;
      chk_empty("rst_mid");
      chk("rst_mid_op",  64'(issue_opcode), 64'd0);
      chk("rst_mid_rs1", 64'(issue_rs1_data), 64'd0);
      chk("rst_mid_rs2", 64'(issue_rs2_data), 64'd0);
      chk("rst_mid_rd",  64'(issue_rd_tag), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
